regfile_wb_arbiter: RTL and testbench

- Shares the register file's single write port (Regwrite/rd/Write_data) between two writers:
  - requester A: the main writeback path, single-cycle ALU/load results;
  - requester B: a long-latency unit (mult/div), whose results are buffered in a small FIFO.
- Keeps a 32-entry pending scoreboard of B destinations, so decode can stall on RAW hazards. A is stalled on WAW hazards.
- Sits between the writeback stage and the register file, and drives its write port directly.

---
 rtl/regfile_wb_pkg.sv | 19 +
 rtl/wb_fifo.sv | 61 ++++++
 rtl/regfile_wb_arbiter.sv | 161 ++++++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_wb_pkg.sv
// Shared types for the register-file writeback arbiter: default widths,
// the grant encoding and the buffered B-result entry.
package regfile_wb_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_A,
        GNT_B
    } grant_e;

    typedef struct packed {
        logic [ADDR_W-1:0] rd;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Small synchronous FIFO (power-of-two depth, no bypass) buffering
// long-latency results until they win the register-file write port.
module wb_fifo #(
    parameter int W     = 37,
    parameter int DEPTH = 2
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             wdata,
    output logic [W-1:0]             rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q + CW'(push) - CW'(pop);
        if (push) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
    end

    // Storage carries no reset; only the pointers and count define validity.
    always_ff @(posedge clock) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign rdata = mem_q[rd_ptr_q];
    assign count = count_q;
    assign empty = (count_q == '0);

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the register file's single write port between the main
// writeback path (A) and a FIFO-buffered long-latency unit (B), and tracks
// outstanding B destinations for RAW/WAW stalls.
// Optional macro WB_STARVE_GUARD_EN forces a B grant after STARVE_MAX
// consecutive cycles in which buffered B results were passed over.
module regfile_wb_arbiter #(
    parameter int DATA_W     = regfile_wb_pkg::DATA_W,
    parameter int ADDR_W     = regfile_wb_pkg::ADDR_W,
    parameter int BUF_DEPTH  = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         a_valid,
    input  logic [ADDR_W-1:0]            a_rd,
    input  logic [DATA_W-1:0]            a_data,
    output logic                         a_stall,
    input  logic                         b_valid,
    output logic                         b_ready,
    input  logic [ADDR_W-1:0]            b_rd,
    input  logic [DATA_W-1:0]            b_data,
    input  logic                         issue_valid,
    input  logic [ADDR_W-1:0]            issue_rd,
    input  logic [ADDR_W-1:0]            rs,
    input  logic [ADDR_W-1:0]            rt,
    output logic                         stall_rs,
    output logic                         stall_rt,
    output logic                         Regwrite,
    output logic [ADDR_W-1:0]            rd,
    output logic [DATA_W-1:0]            Write_data,
    output logic [$clog2(BUF_DEPTH):0]   fifo_count
);

    import regfile_wb_pkg::*;

    localparam int CW = $clog2(BUF_DEPTH) + 1;
    localparam int NREG = 2 ** ADDR_W;

    grant_e             gnt;
    wb_entry_t          head;
    wb_entry_t          push_entry;
    logic               fifo_empty;
    logic               push;
    logic               pop;
    logic               force_b;

    logic [NREG-1:0]    pending_q, pending_d;
    logic               regwrite_q, regwrite_d;
    logic [ADDR_W-1:0]  rd_q, rd_d;
    logic [DATA_W-1:0]  write_data_q, write_data_d;

    assign push_entry = '{rd: b_rd, data: b_data};
    assign b_ready    = (fifo_count < CW'(BUF_DEPTH));
    assign push       = b_valid && b_ready;
    assign pop        = (gnt == GNT_B);

    wb_fifo #(
        .W     ($bits(wb_entry_t)),
        .DEPTH (BUF_DEPTH)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .wdata (push_entry),
        .rdata (head),
        .count (fifo_count),
        .empty (fifo_empty)
    );

`ifdef WB_STARVE_GUARD_EN
    localparam int SW = $clog2(STARVE_MAX + 1);

    logic [SW-1:0] starve_q, starve_d;

    assign force_b = (starve_q == SW'(STARVE_MAX)) && !fifo_empty;

    always_comb begin
        starve_d = starve_q;
        if (gnt == GNT_B || fifo_empty) begin
            starve_d = '0;
        end else if (starve_q != SW'(STARVE_MAX)) begin
            starve_d = starve_q + SW'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end
`else
    assign force_b = 1'b0;
`endif

    assign a_stall  = (a_valid && pending_q[a_rd]) || force_b;
    assign stall_rs = pending_q[rs];
    assign stall_rt = pending_q[rt];

    always_comb begin
        gnt = GNT_NONE;
        if (a_valid && !a_stall) begin
            gnt = GNT_A;
        end else if (!fifo_empty) begin
            gnt = GNT_B;
        end
    end

    // Winner's write is registered; address/data hold when nobody wins.
    always_comb begin
        regwrite_d   = 1'b0;
        rd_d         = rd_q;
        write_data_d = write_data_q;
        case (gnt)
            GNT_A: begin
                regwrite_d   = (a_rd != '0);
                rd_d         = a_rd;
                write_data_d = a_data;
            end
            GNT_B: begin
                regwrite_d   = (head.rd != '0);
                rd_d         = head.rd;
                write_data_d = head.data;
            end
            default: ;
        endcase
    end

    // Clear before set so a same-cycle reissue of the retiring register stays pending.
    always_comb begin
        pending_d = pending_q;
        if (gnt == GNT_B) begin
            pending_d[head.rd] = 1'b0;
        end
        if (issue_valid && issue_rd != '0) begin
            pending_d[issue_rd] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pending_q    <= '0;
            regwrite_q   <= 1'b0;
            rd_q         <= '0;
            write_data_q <= '0;
        end else begin
            pending_q    <= pending_d;
            regwrite_q   <= regwrite_d;
            rd_q         <= rd_d;
            write_data_q <= write_data_d;
        end
    end

    assign Regwrite   = regwrite_q;
    assign rd         = rd_q;
    assign Write_data = write_data_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Randomized and directed bench for regfile_wb_arbiter against a
// queue-based reference model of the arbitration and scoreboard rules.
module tb_regfile_wb_arbiter;

    localparam int DATA_W     = 32;
    localparam int ADDR_W     = 5;
    localparam int BUF_DEPTH  = 2;
    localparam int STARVE_MAX = 4;

    logic              clock = 1'b0;
    logic              reset;
    logic              a_valid;
    logic [ADDR_W-1:0] a_rd;
    logic [DATA_W-1:0] a_data;
    logic              a_stall;
    logic              b_valid;
    logic              b_ready;
    logic [ADDR_W-1:0] b_rd;
    logic [DATA_W-1:0] b_data;
    logic              issue_valid;
    logic [ADDR_W-1:0] issue_rd;
    logic [ADDR_W-1:0] rs;
    logic [ADDR_W-1:0] rt;
    logic              stall_rs;
    logic              stall_rt;
    logic              Regwrite;
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] Write_data;
    logic [$clog2(BUF_DEPTH):0] fifo_count;

    always #5 clock = ~clock;

    regfile_wb_arbiter #(
        .DATA_W     (DATA_W),
        .ADDR_W     (ADDR_W),
        .BUF_DEPTH  (BUF_DEPTH),
        .STARVE_MAX (STARVE_MAX)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .a_valid     (a_valid),
        .a_rd        (a_rd),
        .a_data      (a_data),
        .a_stall     (a_stall),
        .b_valid     (b_valid),
        .b_ready     (b_ready),
        .b_rd        (b_rd),
        .b_data      (b_data),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .rs          (rs),
        .rt          (rt),
        .stall_rs    (stall_rs),
        .stall_rt    (stall_rt),
        .Regwrite    (Regwrite),
        .rd          (rd),
        .Write_data  (Write_data),
        .fifo_count  (fifo_count)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    typedef struct {
        logic [ADDR_W-1:0] rd;
        logic [DATA_W-1:0] data;
    } ent_t;

    ent_t              mq[$];
    bit                m_pend[32];
    int                m_starve;
    bit                exp_we;
    logic [ADDR_W-1:0] exp_rd;
    logic [DATA_W-1:0] exp_data;
    bit                last_stall;
    bit                cyc_a_stall, cyc_b_ready, cyc_stall_rs;
    int                cyc_count;

    task automatic model_reset();
        mq.delete();
        foreach (m_pend[i]) m_pend[i] = 1'b0;
        m_starve   = 0;
        exp_we     = 1'b0;
        exp_rd     = '0;
        exp_data   = '0;
        last_stall = 1'b0;
    endtask

    // Called just after a negedge with this cycle's inputs already driven.
    task automatic run_cycle();
        bit   force_b, st;
        int   g, sz;
        ent_t h;
        #1;
        sz = mq.size();
`ifdef WB_STARVE_GUARD_EN
        force_b = (m_starve == STARVE_MAX) && (sz > 0);
`else
        force_b = 1'b0;
`endif
        st = (a_valid && m_pend[a_rd]) || force_b;
        g  = (a_valid && !st) ? 1 : ((sz > 0) ? 2 : 0);
        check("a_stall", a_stall, st);
        check("b_ready", b_ready, sz < BUF_DEPTH);
        check("fifo_count", fifo_count, sz);
        check("stall_rs", stall_rs, m_pend[rs]);
        check("stall_rt", stall_rt, m_pend[rt]);
        cyc_a_stall  = a_stall;
        cyc_b_ready  = b_ready;
        cyc_stall_rs = stall_rs;
        cyc_count    = int'(fifo_count);
        if (g == 1) begin
            exp_we   = (a_rd != 0);
            exp_rd   = a_rd;
            exp_data = a_data;
        end else if (g == 2) begin
            h        = mq.pop_front();
            exp_we   = (h.rd != 0);
            exp_rd   = h.rd;
            exp_data = h.data;
            m_pend[h.rd] = 1'b0;
        end else begin
            exp_we = 1'b0;
        end
        if (b_valid && sz < BUF_DEPTH) mq.push_back('{rd: b_rd, data: b_data});
        if (issue_valid && issue_rd != 0) m_pend[issue_rd] = 1'b1;
        if (g == 2 || sz == 0) m_starve = 0;
        else if (m_starve < STARVE_MAX) m_starve++;
        last_stall = st;
        @(negedge clock);
        check("Regwrite", Regwrite, exp_we);
        check("rd", rd, exp_rd);
        check("Write_data", Write_data, exp_data);
    endtask

    task automatic idle_inputs();
        a_valid = 0; a_rd = 0; a_data = 0;
        b_valid = 0; b_rd = 0; b_data = 0;
        issue_valid = 0; issue_rd = 0; rs = 0; rt = 0;
    endtask

    int nb;

    initial begin
        reset = 1'b1;
        idle_inputs();
        model_reset();
        repeat (2) @(negedge clock);
        #1;
        check("rst_Regwrite", Regwrite, 0);
        check("rst_rd", rd, 0);
        check("rst_Write_data", Write_data, 0);
        check("rst_fifo_count", fifo_count, 0);
        check("rst_b_ready", b_ready, 1);
        @(negedge clock);
        reset = 1'b0;

        // Plain A write, then idle.
        a_valid = 1; a_rd = 3; a_data = 32'hDEADBEEF;
        run_cycle();
        check("t1_we", Regwrite, 1);
        check("t1_rd", rd, 3);
        check("t1_data", Write_data, 32'hDEADBEEF);
        a_valid = 0;
        run_cycle();
        check("t1_we_after", Regwrite, 0);

        // Issue r8, B delivers it, RAW stall clears after the grant.
        issue_valid = 1; issue_rd = 8;
        run_cycle();
        issue_valid = 0; rs = 8; rt = 8;
        b_valid = 1; b_rd = 8; b_data = 32'h55;
        run_cycle();
        check("t2_stall_rs", cyc_stall_rs, 1);
        b_valid = 0;
        run_cycle();
        check("t2_we", Regwrite, 1);
        check("t2_rd", rd, 8);
        check("t2_data", Write_data, 32'h55);
        run_cycle();
        check("t2_stall_cleared", cyc_stall_rs, 0);

        // Fill FIFO behind a busy A path, third push must wait.
        a_valid = 1; a_rd = 1; a_data = 32'h11;
        b_valid = 1; b_rd = 9;  b_data = 32'h101;
        run_cycle();
        b_rd = 10; b_data = 32'h102;
        run_cycle();
        b_rd = 11; b_data = 32'h103;
        run_cycle();
        check("t3_full_ready", cyc_b_ready, 0);
        check("t3_full_count", cyc_count, 2);
        a_valid = 0;
        for (int i = 0; i < 8; i++) begin
            run_cycle();
            if (b_valid && cyc_b_ready) b_valid = 0;
        end
        check("t3_drained", fifo_count, 0);

        // WAW: A to r5 waits for B's r5 write, then overwrites it.
        issue_valid = 1; issue_rd = 5;
        run_cycle();
        issue_valid = 0;
        a_valid = 1; a_rd = 5; a_data = 32'hA5;
        b_valid = 1; b_rd = 5; b_data = 32'h77;
        run_cycle();
        check("t4_stall0", cyc_a_stall, 1);
        b_valid = 0;
        run_cycle();
        check("t4_stall1", cyc_a_stall, 1);
        check("t4_b_data", Write_data, 32'h77);
        run_cycle();
        check("t4_stall2", cyc_a_stall, 0);
        check("t4_a_data", Write_data, 32'hA5);
        a_valid = 0;
        run_cycle();

        // A to r0: accepted, no write.
        a_valid = 1; a_rd = 0; a_data = 32'h1234;
        run_cycle();
        check("t5_stall", cyc_a_stall, 0);
        check("t5_we", Regwrite, 0);
        a_valid = 0;
        run_cycle();

        // A every cycle with B results waiting.
        nb = 0;
        b_valid = 1; b_rd = 12; b_data = $urandom;
        for (int i = 0; i < 30; i++) begin
            if (!last_stall) begin
                a_valid = 1; a_rd = 20; a_data = $urandom;
            end
            run_cycle();
            if (Regwrite && rd >= 9 && rd <= 15) nb++;
            if (b_valid && cyc_b_ready) begin
                b_rd = ADDR_W'($urandom_range(9, 15)); b_data = $urandom;
            end
        end
`ifdef WB_STARVE_GUARD_EN
        check("t6_b_served", nb > 0, 1);
`else
        check("t6_b_starved", nb, 0);
`endif
        a_valid = 0; b_valid = 0;
        for (int i = 0; i < 4; i++) run_cycle();

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            if (!last_stall) begin
                a_valid = ($urandom_range(0, 2) != 0);
                a_rd    = ADDR_W'($urandom_range(0, 7));
                a_data  = $urandom;
            end
            if (!(b_valid && !cyc_b_ready)) begin
                b_valid = ($urandom_range(0, 1) != 0);
                b_rd    = ADDR_W'($urandom_range(0, 7));
                b_data  = $urandom;
            end
            issue_valid = ($urandom_range(0, 3) == 0);
            issue_rd    = ADDR_W'($urandom_range(0, 7));
            rs          = ADDR_W'($urandom_range(0, 7));
            rt          = ADDR_W'($urandom_range(0, 7));
            run_cycle();
        end
        idle_inputs();
        for (int i = 0; i < 6; i++) run_cycle();

        // Reset mid-operation with a full FIFO and pending bits set.
        a_valid = 1; a_rd = 21; a_data = 32'hCAFE;
        issue_valid = 1; issue_rd = 6;
        b_valid = 1; b_rd = 12; b_data = 32'h1;
        run_cycle();
        issue_valid = 0; b_data = 32'h2;
        run_cycle();
        b_valid = 0; rs = 6;
        #2;
        check("t7_pre_count", fifo_count, 2);
        check("t7_pre_stall_rs", stall_rs, 1);
        check("t7_pre_we", Regwrite, 1);
        reset = 1'b1;
        #1;
        check("t7_Regwrite", Regwrite, 0);
        check("t7_rd", rd, 0);
        check("t7_Write_data", Write_data, 0);
        check("t7_fifo_count", fifo_count, 0);
        check("t7_stall_rs", stall_rs, 0);
        check("t7_b_ready", b_ready, 1);
        @(negedge clock);
        reset = 1'b0;
        idle_inputs();
        rs = 6;
        model_reset();
        for (int i = 0; i < 3; i++) run_cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1);
    end

endmodule
